myip_axil_selftest_seq: RTL

MYIP_AXIL_SELFTEST_SEQ -- requirements
Module: myip_axil_selftest_seq

---
 rtl/myip_axil_selftest_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/myip_axil_selftest_seq.sv
// AXI4-Lite master self-test sequencer: writes SEED+k to NUM_REGS registers,
// reads them back, and reports the number of bad responses or data mismatches.
module myip_axil_selftest_seq #(
  parameter int unsigned NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FIN
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] idx_next;
  logic       aw_done;
  logic       w_done;
  logic       aw_fire;
  logic       w_fire;
  logic       wr_err;
  logic       rd_err;
  logic [7:0] err_wr_next;
  logic [7:0] err_rd_next;

  function automatic logic [31:0] reg_addr(input logic [3:0] k);
    return BASE_ADDR + {26'd0, k, 2'b00};
  endfunction

  function automatic logic [31:0] reg_data(input logic [3:0] k);
    return SEED + {28'd0, k};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign M_AXI_WSTRB = 4'hF;

  always_comb begin
    aw_fire     = M_AXI_AWVALID & M_AXI_AWREADY;
    w_fire      = M_AXI_WVALID & M_AXI_WREADY;
    idx_next    = idx + 4'd1;
    wr_err      = (M_AXI_BRESP != 2'b00);
    // A beat with both bad data and bad response still counts once.
    rd_err      = (M_AXI_RDATA != reg_data(idx)) || (M_AXI_RRESP != 2'b00);
    err_wr_next = wr_err ? sat_inc(err_cnt) : err_cnt;
    err_rd_next = rd_err ? sat_inc(err_cnt) : err_cnt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      idx           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            err_cnt       <= '0;
            pass          <= 1'b0;
            busy          <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= reg_addr(4'd0);
            M_AXI_WDATA   <= reg_data(4'd0);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WR_REQ;
          end
        end

        WR_REQ: begin
          // AW and W complete independently; leave once both have handshaken.
          if (aw_fire) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            err_cnt      <= err_wr_next;
            if (idx != LAST_IDX) begin
              idx           <= idx_next;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              M_AXI_AWADDR  <= reg_addr(idx_next);
              M_AXI_WDATA   <= reg_data(idx_next);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              idx           <= '0;
              M_AXI_ARADDR  <= reg_addr(4'd0);
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            err_cnt      <= err_rd_next;
            if (idx == LAST_IDX) begin
              // Verdict uses the count including this final beat.
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_rd_next == 8'd0);
              state <= FIN;
            end else begin
              idx           <= idx_next;
              M_AXI_ARADDR  <= reg_addr(idx_next);
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
